// File: rtl/ahb_gpio_pkg.sv
// ahb_gpio_pkg
//   Shared definitions for the AHB-Lite GPIO slave:
//   - byte offsets of every register in the map
//   - AHB HTRANS / HSIZE encodings
//   - byte_strobes(): byte-lane enables for a transfer, from HSIZE and HADDR[1:0]
package ahb_gpio_pkg;

    localparam logic [7:0] GPIO_OUT      = 8'h00;
    localparam logic [7:0] GPIO_DIR      = 8'h04;
    localparam logic [7:0] GPIO_IN       = 8'h08;
    localparam logic [7:0] GPIO_OUT_SET  = 8'h0C;
    localparam logic [7:0] GPIO_OUT_CLR  = 8'h10;
    localparam logic [7:0] GPIO_OUT_TGL  = 8'h14;
    localparam logic [7:0] GPIO_RISE_EN  = 8'h18;
    localparam logic [7:0] GPIO_FALL_EN  = 8'h1C;
    localparam logic [7:0] GPIO_IRQ_STAT = 8'h20;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    // Sizes wider than a word are not supported by this slave.
    // They are treated as a full word.
    function automatic logic [3:0] byte_strobes(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] s;
        case (size)
            HSIZE_BYTE: s = 4'b0001 << addr_lo;
            HSIZE_HALF: s = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ahb_gpio_sync_edge.sv
// gpio_sync_edge
//   Multi-flop synchroniser for asynchronous pad inputs, plus a one-cycle history of
//   the synchronised value. It is used to detect edges.
//   Ports:
//     clk, rst  clock and asynchronous active-high reset
//     din       asynchronous pin inputs
//     in_s      synchronised inputs (STAGES cycles after din)
//     rise      in_s went 0->1 this cycle
//     fall      in_s went 1->0 this cycle
module gpio_sync_edge #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] in_s,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    // sync_q[0] samples the pad. sync_q[STAGES-1] is the synchronised value.
    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]             in_d_q, in_d_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        in_d_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            in_d_q <= '0;
        end else begin
            sync_q <= sync_d;
            in_d_q <= in_d_d;
        end
    end

    assign in_s = sync_q[STAGES-1];
    assign rise = in_s & ~in_d_q;
    assign fall = ~in_s & in_d_q;

endmodule

// File: rtl/ahb_gpio.sv
// ahb_gpio
//   AHB-Lite GPIO slave. It has zero wait states and always returns an OKAY response.
//   Features:
//   - per-pin output value and direction
//   - synchronised inputs
//   - atomic set / clear / toggle of OUT
//   - sticky rising/falling edge flags that drive a level interrupt
//   Ports:
//     HCLK, HRESET          clock, asynchronous active-high reset
//     HSEL, HADDR, HTRANS,  AHB address phase
//     HSIZE, HWRITE, HREADY
//     HWDATA                AHB write data (data phase)
//     HREADYOUT, HRESP      tied to 1 / OKAY
//     HRDATA                read data, 0 outside a read data phase
//     gpio_i                asynchronous pad inputs
//     gpio_o, gpio_oe       pad output values and enables (1 = drive)
//     irq                   registered OR of IRQ_STAT
module ahb_gpio
    import ahb_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);
    localparam int W = GPIO_WIDTH;

    logic [W-1:0] in_s, rise, fall;

    gpio_sync_edge #(.WIDTH(W), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (HCLK),
        .rst  (HRESET),
        .din  (gpio_i),
        .in_s (in_s),
        .rise (rise),
        .fall (fall)
    );

    // Handshake: an address phase is taken when HSEL & HREADY & HTRANS[1]
    // (NONSEQ/SEQ). Because HREADYOUT is always 1, the matching data phase is the
    // next cycle. The latch only moves when HREADY is high, so a stalled bus
    // holds the pending transfer.
    logic                  active_q, active_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-3:0] addr_q, addr_d;
    logic [3:0]            strb_q, strb_d;

    logic [W-1:0] out_q, out_d;
    logic [W-1:0] dir_q, dir_d;
    logic [W-1:0] rise_en_q, rise_en_d;
    logic [W-1:0] fall_en_q, fall_en_d;
    logic [W-1:0] stat_q, stat_d;
    logic         irq_q, irq_d;

    logic [ADDR_WIDTH-1:0] off;
    logic [31:0]           bmask;
    logic [W-1:0]          wbits, wmask, w1c, rd_val;
    logic                  unused_bits;

    always_comb begin
        active_d = active_q;
        write_d  = write_q;
        addr_d   = addr_q;
        strb_d   = strb_q;
        if (HREADY) begin
            active_d = HSEL & HTRANS[1];
            write_d  = HWRITE;
            addr_d   = HADDR[ADDR_WIDTH-1:2];
            strb_d   = byte_strobes(HSIZE, HADDR[1:0]);
        end
    end

    // The full latched address is decoded.
    // Offsets beyond the map do not alias onto real registers.
    assign off   = {addr_q, 2'b00};
    assign bmask = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
    assign wmask = bmask[W-1:0];
    assign wbits = HWDATA[W-1:0] & wmask;

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (active_q && write_q && HREADY) begin
            case (off)
                ADDR_WIDTH'(GPIO_OUT):      out_d     = (out_q & ~wmask) | wbits;
                ADDR_WIDTH'(GPIO_DIR):      dir_d     = (dir_q & ~wmask) | wbits;
                ADDR_WIDTH'(GPIO_OUT_SET):  out_d     = out_q | wbits;
                ADDR_WIDTH'(GPIO_OUT_CLR):  out_d     = out_q & ~wbits;
                ADDR_WIDTH'(GPIO_OUT_TGL):  out_d     = out_q ^ wbits;
                ADDR_WIDTH'(GPIO_RISE_EN):  rise_en_d = (rise_en_q & ~wmask) | wbits;
                ADDR_WIDTH'(GPIO_FALL_EN):  fall_en_d = (fall_en_q & ~wmask) | wbits;
                ADDR_WIDTH'(GPIO_IRQ_STAT): w1c       = wbits;
                default: ;
            endcase
        end
        // The set term is ORed in after the clear, so a new edge beats a same-cycle W1C.
        stat_d = (stat_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d  = |stat_q;
    end

    always_comb begin
        rd_val = '0;
        case (off)
            ADDR_WIDTH'(GPIO_OUT):      rd_val = out_q;
            ADDR_WIDTH'(GPIO_DIR):      rd_val = dir_q;
            ADDR_WIDTH'(GPIO_IN):       rd_val = in_s;
            ADDR_WIDTH'(GPIO_RISE_EN):  rd_val = rise_en_q;
            ADDR_WIDTH'(GPIO_FALL_EN):  rd_val = fall_en_q;
            ADDR_WIDTH'(GPIO_IRQ_STAT): rd_val = stat_q;
            default:                    rd_val = '0;
        endcase
        HRDATA = (active_q && !write_q) ? 32'(rd_val) : 32'h0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            active_q  <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            strb_q    <= '0;
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            active_q  <= active_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            irq_q     <= irq_d;
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign gpio_o    = out_q;
    assign gpio_oe   = dir_q;
    assign irq       = irq_q;

    // Upper data lanes beyond GPIO_WIDTH and HTRANS[0] carry no meaning here.
    assign unused_bits = ^{HTRANS[0], HWDATA, bmask};

endmodule

// File: tb/tb_ahb_gpio.sv
// tb_ahb_gpio
//   Directed bench for ahb_gpio with GPIO_WIDTH=16 and SYNC_STAGES=2.
//   A transaction-level model of the register map and the pin sampling pipeline runs alongside the DUT.
//   Every cycle, a compare process checks the pins, irq and the AHB outputs against that model.
//   The directed tests also pin key values to hand-computed literals.
module tb_ahb_gpio;
    localparam int W  = 16;
    localparam int S  = 2;
    localparam int AW = 12;

    localparam logic [AW-1:0] A_OUT  = 12'h000;
    localparam logic [AW-1:0] A_DIR  = 12'h004;
    localparam logic [AW-1:0] A_IN   = 12'h008;
    localparam logic [AW-1:0] A_SET  = 12'h00C;
    localparam logic [AW-1:0] A_CLR  = 12'h010;
    localparam logic [AW-1:0] A_TGL  = 12'h014;
    localparam logic [AW-1:0] A_REN  = 12'h018;
    localparam logic [AW-1:0] A_FEN  = 12'h01C;
    localparam logic [AW-1:0] A_STAT = 12'h020;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          hsel   = 1'b0;
    logic [AW-1:0] haddr  = '0;
    logic [1:0]    htrans = 2'b00;
    logic [2:0]    hsize  = 3'd2;
    logic          hwrite = 1'b0;
    logic          hready = 1'b1;
    logic [31:0]   hwdata = '0;
    logic          hreadyout, hresp;
    logic [31:0]   hrdata;
    logic [W-1:0]  gpio_i = '0;
    logic [W-1:0]  gpio_o, gpio_oe;
    logic          irq;

    ahb_gpio #(.GPIO_WIDTH(W), .SYNC_STAGES(S), .ADDR_WIDTH(AW)) dut (
        .HCLK      (clk),
        .HRESET    (rst),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HSIZE     (hsize),
        .HWRITE    (hwrite),
        .HREADY    (hready),
        .HWDATA    (hwdata),
        .HREADYOUT (hreadyout),
        .HRDATA    (hrdata),
        .HRESP     (hresp),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]  m_out = '0, m_dir = '0, m_ren = '0, m_fen = '0, m_stat = '0;
    logic          m_irq = 1'b0;
    logic [W-1:0]  m_hist[$];          // pad samples, newest first; [S-1] is the synchronised value
    logic          m_dp_valid = 1'b0, m_dp_write = 1'b0;
    logic [AW-1:0] m_dp_addr = '0;
    logic [2:0]    m_dp_size = '0;
    logic [W-1:0]  m_rise, m_fall, m_set, m_w1c, m_wd, m_wm;
    logic          m_irq_next;

    function automatic logic [31:0] lane_mask(input logic [2:0] sz, input logic [1:0] lo);
        int nb, first;
        logic [31:0] m;
        m     = '0;
        nb    = 1 << sz;
        first = int'(lo) & ~(nb - 1);
        for (int b = 0; b < 4; b++)
            if (b >= first && b < first + nb) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        case (int'(a >> 2))
            0: return 32'(m_out);
            1: return 32'(m_dir);
            2: return 32'(m_hist[S-1]);
            6: return 32'(m_ren);
            7: return 32'(m_fen);
            8: return 32'(m_stat);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = '0; m_dir = '0; m_ren = '0; m_fen = '0; m_stat = '0; m_irq = 1'b0;
            m_dp_valid = 1'b0; m_dp_write = 1'b0; m_dp_addr = '0; m_dp_size = '0;
            m_hist.delete();
            for (int i = 0; i <= S; i++) m_hist.push_front('0);
        end else begin
            m_rise     = m_hist[S-1] & ~m_hist[S];
            m_fall     = ~m_hist[S-1] & m_hist[S];
            m_set      = (m_rise & m_ren) | (m_fall & m_fen);
            m_irq_next = (m_stat != '0);
            m_w1c      = '0;
            if (m_dp_valid && m_dp_write) begin
                m_wm = W'(lane_mask(m_dp_size, m_dp_addr[1:0]));
                m_wd = W'(hwdata) & m_wm;
                case (int'(m_dp_addr >> 2))
                    0: m_out = (m_out & ~m_wm) | m_wd;
                    1: m_dir = (m_dir & ~m_wm) | m_wd;
                    3: m_out = m_out | m_wd;
                    4: m_out = m_out & ~m_wd;
                    5: m_out = m_out ^ m_wd;
                    6: m_ren = (m_ren & ~m_wm) | m_wd;
                    7: m_fen = (m_fen & ~m_wm) | m_wd;
                    8: m_w1c = m_wd;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~m_w1c) | m_set;
            m_irq  = m_irq_next;
            m_hist.push_front(gpio_i);
            void'(m_hist.pop_back());
            if (hready) begin
                m_dp_valid = hsel & htrans[1];
                m_dp_write = hwrite;
                m_dp_addr  = haddr;
                m_dp_size  = hsize;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] exp_rd;
    always @(negedge clk) begin
        exp_rd = (m_dp_valid && !m_dp_write) ? model_read(m_dp_addr) : 32'h0;
        check("cyc_gpio_o",    32'(gpio_o),    32'(m_out));
        check("cyc_gpio_oe",   32'(gpio_oe),   32'(m_dir));
        check("cyc_irq",       32'(irq),       32'(m_irq));
        check("cyc_hreadyout", 32'(hreadyout), 32'h1);
        check("cyc_hresp",     32'(hresp),     32'h0);
        check("cyc_hrdata",    hrdata,         exp_rd);
    end

    // ---------------- gpio_o transition scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_o = '0;
    bit           track_o = 1'b0;
    always @(negedge clk) begin
        if (track_o && gpio_o !== last_o) begin
            if (exp_q.size() == 0) check("gpio_o_seq_extra", 32'(gpio_o), 32'(last_o));
            else                   check("gpio_o_seq", 32'(gpio_o), 32'(exp_q.pop_front()));
        end
        last_o = gpio_o;
    end

    // ---------------- driver tasks ----------------
    // Calls start just after a rising edge. Each call drives one address phase,
    // together with the data-phase HWDATA of the previous transfer.
    logic [31:0] next_wdata = '0;

    task automatic bus(input logic wr, input logic [AW-1:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [1:0] tr);
        hsel = 1'b1; htrans = tr; haddr = a; hsize = sz; hwrite = wr;
        hwdata = next_wdata; next_wdata = wd;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] wd);
        bus(1'b1, a, 3'd2, wd, 2'b10);
    endtask

    task automatic idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        hwdata = next_wdata; next_wdata = '0;
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
        bus(1'b0, a, 3'd2, 32'h0, 2'b10);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        hwdata = next_wdata; next_wdata = '0;
        @(negedge clk);
        check(name, hrdata, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_hrdata", hrdata, 32'h0);
        @(posedge clk); #1;

        // 1: build up state, then reset in the middle of a write data phase
        wr(A_OUT, 32'h55);
        wr(A_DIR, 32'hF0);
        wr(A_REN, 32'h4);
        idle();
        gpio_i = 16'h0004;
        repeat (5) idle();
        @(negedge clk);
        check("pre_rst_irq", 32'(irq), 32'h1);
        @(posedge clk); #1;
        gpio_i = 16'h0000;
        bus(1'b1, A_OUT, 3'd2, 32'hFFFF, 2'b10);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = next_wdata; next_wdata = '0;
        #1 rst = 1'b1;
        #1;
        check("midrst_gpio_o", 32'(gpio_o), 32'h0);
        check("midrst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_hreadyout", 32'(hreadyout), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_chk("rst_out", A_OUT, 32'h0);
        rd_chk("rst_dir", A_DIR, 32'h0);
        rd_chk("rst_in", A_IN, 32'h0);
        rd_chk("rst_ren", A_REN, 32'h0);
        rd_chk("rst_fen", A_FEN, 32'h0);
        rd_chk("rst_stat", A_STAT, 32'h0);

        // 2: back-to-back OUT / DIR / SET / CLR / TGL
        exp_q.push_back(16'h00A5);
        exp_q.push_back(16'h00AF);
        exp_q.push_back(16'h002E);
        exp_q.push_back(16'h00D1);
        track_o = 1'b1;
        wr(A_OUT, 32'hA5);
        wr(A_DIR, 32'hFF);
        wr(A_SET, 32'h0A);
        wr(A_CLR, 32'h81);
        wr(A_TGL, 32'hFF);
        rd_chk("out_after_tgl", A_OUT, 32'hD1);
        rd_chk("out_set_reads0", A_SET, 32'h0);
        rd_chk("out_tgl_reads0", A_TGL, 32'h0);
        check("gpio_o_seq_done", 32'(exp_q.size()), 32'h0);
        check("dir_ff", 32'(gpio_oe), 32'h00FF);
        track_o = 1'b0;

        // 3: byte / half-word lanes and the width mask
        wr(A_OUT, 32'h0);
        bus(1'b1, 12'h001, 3'd0, 32'h0000_3C00, 2'b10);
        rd_chk("byte_lane1", A_OUT, 32'h3C00);
        bus(1'b1, 12'h002, 3'd1, 32'h1234_0000, 2'b10);
        rd_chk("half_upper_ignored", A_OUT, 32'h3C00);
        wr(A_DIR, 32'hFFFF_FFFF);
        rd_chk("dir_width_mask", A_DIR, 32'h0000_FFFF);
        bus(1'b1, 12'h000, 3'd1, 32'hBEEF_00A5, 2'b10);
        rd_chk("half_lower", A_OUT, 32'h0000_00A5);

        // 4: edge capture and irq latency
        gpio_i = 16'h0002;
        repeat (5) idle();
        wr(A_REN, 32'h1);
        wr(A_FEN, 32'h2);
        idle();
        rd_chk("stat_before_edges", A_STAT, 32'h0);
        gpio_i = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("irq_low_at_3", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_high_at_4", 32'(irq), 32'h1);
        @(posedge clk); #1;
        rd_chk("stat_rise_fall", A_STAT, 32'h3);
        rd_chk("in_value", A_IN, 32'h0001);

        // 5: W1C colliding with a new rising edge, then a full clear
        gpio_i = 16'h0000;
        repeat (4) idle();
        gpio_i = 16'h0001;
        idle();
        bus(1'b1, A_STAT, 3'd2, 32'h1, 2'b10);
        idle();
        rd_chk("w1c_vs_rise", A_STAT, 32'h3);
        bus(1'b1, A_STAT, 3'd2, 32'h3, 2'b10);
        idle();
        @(negedge clk);
        check("irq_after_clear_0", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_after_clear_1", 32'(irq), 32'h0);
        @(posedge clk); #1;
        rd_chk("stat_cleared", A_STAT, 32'h0);

        // 6: unmapped, IDLE/BUSY, alias, deselected
        rd_chk("unmapped_0x40", 12'h040, 32'h0);
        bus(1'b1, A_OUT, 3'd2, 32'hFFFF, 2'b00);
        bus(1'b1, A_OUT, 3'd2, 32'hFFFF, 2'b01);
        bus(1'b1, 12'h800, 3'd2, 32'hFFFF, 2'b10);
        hsel = 1'b0; htrans = 2'b10; haddr = A_OUT; hsize = 3'd2; hwrite = 1'b1;
        hwdata = next_wdata; next_wdata = 32'hFFFF;
        @(posedge clk); #1;
        idle();
        check("no_write_gpio_o", 32'(gpio_o), 32'h00A5);
        rd_chk("no_write_out", A_OUT, 32'h00A5);

        repeat (3) idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
